// File: rtl/intpol2_out_buffer.sv
// intpol2_out_buffer
// Output FIFO for the interpolator. Samples are written at the interpolator
// rate and drained at a programmable rate. The drain rate is set by a tick
// divider. The level register drives the back-pressure and status flags.
// Overflow and underflow events are held in sticky flags until cleared.

module intpol2_out_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_THR  = 12,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  afull_o,
   input  logic                  en_i,
   input  logic [DIV_WIDTH-1:0]  rate_div_i,
   input  logic                  clr_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int                DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] fullLevel  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] afullLevel = (ADDR_WIDTH + 1)'(AFULL_THR);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wrPtr;
   logic [ADDR_WIDTH-1:0] rdPtr;
   logic [ADDR_WIDTH:0]   level;
   logic [DIV_WIDTH-1:0]  tickCnt;
   logic [DATA_WIDTH-1:0] dataReg;
   logic                  validReg;
   logic                  overflowReg;
   logic                  underflowReg;

   logic isEmpty;
   logic isFull;
   logic tick;
   logic pop;
   logic wrAccept;
   logic wrDrop;
   logic tickEmpty;

   // Status flags are decoded from the level register alone. Empty is therefore
   // evaluated at the start of the cycle, and a write never bypasses to the read side.
   assign isEmpty = (level == '0);
   assign isFull  = (level == fullLevel);

   assign empty_o     = isEmpty;
   assign full_o      = isFull;
   assign afull_o     = (level >= afullLevel);
   assign level_o     = level;
   assign data_o      = dataReg;
   assign valid_o     = validReg;
   assign overflow_o  = overflowReg;
   assign underflow_o = underflowReg;

   // Per-cycle control decode: drain tick, pop, write accept/drop
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      tick      = 1'b0;
      pop       = 1'b0;
      wrAccept  = 1'b0;
      wrDrop    = 1'b0;
      tickEmpty = 1'b0;
      if (en_i && (tickCnt >= rate_div_i)) begin
         tick = 1'b1;
      end
      pop       = tick && !isEmpty;
      tickEmpty = tick && isEmpty;
      // A full FIFO still takes a write when a pop frees a slot this cycle
      if (wr_en_i) begin
         if (!isFull || pop) begin
            wrAccept = 1'b1;
         end else begin
            wrDrop = 1'b1;
         end
      end
   end

   // Storage array write port
   // NOTE: the data array has no reset. Its contents are meaningless until
   // written, and the pointers and level decide what is valid. Leaving it
   // unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (wrAccept) begin
         mem[wrPtr] <= data_i;
      end
   end

   // Pointers and level. The pointers wrap modulo DEPTH through natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         if (wrAccept) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (wrAccept && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !wrAccept) begin
            level <= level - 1'b1;
         end
      end
   end

   // Drain-rate divider. It is held at zero while disabled and reloads on every tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tickCnt <= '0;
      end else if (!en_i || tick) begin
         tickCnt <= '0;
      end else begin
         tickCnt <= tickCnt + 1'b1;
      end
   end

   // Registered output: capture the head word on a pop. data_o holds its value otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dataReg  <= '0;
         validReg <= 1'b0;
      end else begin
         validReg <= pop;
         if (pop) begin
            dataReg <= mem[rdPtr];
         end
      end
   end

   // Sticky error flags. A set event takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflowReg  <= 1'b0;
         underflowReg <= 1'b0;
      end else begin
         if (wrDrop) begin
            overflowReg <= 1'b1;
         end else if (clr_i) begin
            overflowReg <= 1'b0;
         end
         if (tickEmpty) begin
            underflowReg <= 1'b1;
         end else if (clr_i) begin
            underflowReg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_intpol2_out_buffer.sv
// tb_intpol2_out_buffer
// Directed and randomized stimulus for the output FIFO. A queue-based
// reference model predicts every output after every clock.

module tb_intpol2_out_buffer;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int AF    = 12;
   localparam int DVW   = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic          en_i = 1'b0;
   logic [DVW-1:0] rate_div_i = '0;
   logic          clr_i = 1'b0;
   logic          afull_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          empty_o;
   logic          full_o;
   logic [AW:0]   level_o;
   logic          overflow_o;
   logic          underflow_o;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   int            mCnt = 0;
   logic [DW-1:0] mData = '0;
   logic          mValid = 1'b0;
   logic          mOvf = 1'b0;
   logic          mUdf = 1'b0;

   intpol2_out_buffer #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AFULL_THR (AF),
      .DIV_WIDTH (DVW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en_i),
      .data_i     (data_i),
      .afull_o    (afull_o),
      .en_i       (en_i),
      .rate_div_i (rate_div_i),
      .clr_i      (clr_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .underflow_o(underflow_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      int lvl;
      lvl = mq.size();
      check({tag, ".data"},  64'(data_o), 64'(mData));
      check({tag, ".valid"}, 64'(valid_o), 64'(mValid));
      check({tag, ".level"}, 64'(level_o), 64'(lvl));
      check({tag, ".empty"}, 64'(empty_o), 64'(lvl == 0));
      check({tag, ".full"},  64'(full_o), 64'(lvl == DEPTH));
      check({tag, ".afull"}, 64'(afull_o), 64'(lvl >= AF));
      check({tag, ".ovf"},   64'(overflow_o), 64'(mOvf));
      check({tag, ".udf"},   64'(underflow_o), 64'(mUdf));
   endtask

   task automatic modelReset();
      mq.delete();
      mCnt   = 0;
      mData  = '0;
      mValid = 1'b0;
      mOvf   = 1'b0;
      mUdf   = 1'b0;
   endtask

   // Apply one cycle of inputs. The model predicts the result, then the task checks
   // the outputs #1 after the edge.
   task automatic step(input string tag, input logic wr, input logic [DW-1:0] d,
                       input logic en, input int rate, input logic clr);
      int lvl;
      bit empty, full, tick, pop, acc, drop;
      wr_en_i    = wr;
      data_i     = d;
      en_i       = en;
      rate_div_i = DVW'(rate);
      clr_i      = clr;
      lvl   = mq.size();
      empty = (lvl == 0);
      full  = (lvl == DEPTH);
      tick  = en && (mCnt >= rate);
      pop   = tick && !empty;
      acc   = wr && (!full || pop);
      drop  = wr && full && !pop;
      mValid = pop;
      if (pop) mData = mq.pop_front();
      if (acc) mq.push_back(d);
      mCnt = (!en || tick) ? 0 : mCnt + 1;
      if (drop) mOvf = 1'b1; else if (clr) mOvf = 1'b0;
      if (tick && empty) mUdf = 1'b1; else if (clr) mUdf = 1'b0;
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   initial begin
      int pulses;
      int lastIdx;
      int expWord;
      logic [DW-1:0] words [4];
      logic [DW-1:0] d;

      // Reset state
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset");
      rst = 1'b1;

      // Fill: 12 writes with the drain disabled
      for (int i = 1; i <= 12; i++) step("fill", 1'b1, DW'(i), 1'b0, 0, 1'b0);
      check("fill.afull12", 64'(afull_o), 64'd1);
      check("fill.level12", 64'(level_o), 64'd12);

      // Overflow: five more writes, the 17th word is dropped
      for (int i = 13; i <= 17; i++) step("ovf", 1'b1, DW'(i), 1'b0, 0, 1'b0);
      check("ovf.full", 64'(full_o), 64'd1);
      check("ovf.level", 64'(level_o), 64'd16);
      check("ovf.flag", 64'(overflow_o), 64'd1);

      // Drain at full rate: 16 strobes carrying words 1..16 in order
      pulses  = 0;
      expWord = 1;
      for (int i = 0; i < 18; i++) begin
         step("drain", 1'b0, '0, 1'b1, 0, 1'b0);
         if (valid_o === 1'b1) begin
            pulses++;
            check("drain.word", 64'(data_o), 64'(expWord));
            expWord++;
         end
      end
      check("drain.pulses", 64'(pulses), 64'd16);

      // Clear with both stickies set
      check("clr.preUdf", 64'(underflow_o), 64'd1);
      step("clr", 1'b0, '0, 1'b0, 0, 1'b1);
      check("clr.ovf0", 64'(overflow_o), 64'd0);
      check("clr.udf0", 64'(underflow_o), 64'd0);

      // Rate: divider 3, four buffered words
      for (int i = 0; i < 4; i++) begin
         words[i] = $urandom;
         step("rateFill", 1'b1, words[i], 1'b0, 3, 1'b0);
      end
      pulses  = 0;
      lastIdx = 0;
      for (int i = 1; i <= 20; i++) begin
         step("rate", 1'b0, '0, 1'b1, 3, 1'b0);
         if (valid_o === 1'b1) begin
            pulses++;
            check("rate.interval", 64'(i - lastIdx), 64'd4);
            lastIdx = i;
         end
      end
      check("rate.pulses", 64'(pulses), 64'd4);
      check("rate.udf", 64'(underflow_o), 64'd1);
      check("rate.lastWord", 64'(data_o), 64'(words[3]));
      step("rateClr", 1'b0, '0, 1'b0, 0, 1'b1);

      // Wrap/concurrency: 40 writes streaming through at full rate
      step("wrap0", 1'b1, $urandom, 1'b0, 0, 1'b0);
      for (int i = 1; i < 40; i++) begin
         d = $urandom;
         step("wrap", 1'b1, d, 1'b1, 0, 1'b0);
         check("wrap.level1", 64'(level_o), 64'd1);
      end
      step("wrapEnd", 1'b0, '0, 1'b1, 0, 1'b0);
      step("wrapIdle", 1'b0, '0, 1'b0, 0, 1'b0);
      check("wrap.ovf", 64'(overflow_o), 64'd0);
      check("wrap.udf", 64'(underflow_o), 64'd0);

      // Clear coinciding with an overflow write: the set wins
      for (int i = 0; i < 16; i++) step("fill2", 1'b1, $urandom, 1'b0, 0, 1'b0);
      step("clrOvf", 1'b1, $urandom, 1'b0, 0, 1'b1);
      check("clrOvf.flag", 64'(overflow_o), 64'd1);

      // Drain 9 words to reach level 7 with valid_o high
      for (int i = 0; i < 9; i++) step("pre", 1'b0, '0, 1'b1, 0, 1'b0);
      check("pre.level7", 64'(level_o), 64'd7);
      check("pre.valid", 64'(valid_o), 64'd1);

      // Asynchronous reset mid-stream
      wr_en_i = 1'b0;
      en_i    = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      modelReset();
      checkAll("rstAsync");
      @(posedge clk);
      #1;
      checkAll("rstHold");
      rst = 1'b1;
      step("postRst", 1'b0, '0, 1'b1, 0, 1'b0);
      check("postRst.udf", 64'(underflow_o), 64'd1);

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         step("rand", 1'($urandom_range(0, 1)), $urandom,
              1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
